game_flow_ctl: RTL and testbench

GAME_FLOW_CTL -- requirements
Module: game_flow_ctl

---
 rtl/game_flow_ctl.sv | 218 +++++++++++++++++++++
 tb/tb_game_flow_ctl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctl.sv
// Penalty shoot-out game flow controller: sequences player/CPU shot pairs,
// keeps score and frame timers, and decides the winner.
module game_flow_ctl #(
    parameter int unsigned ROUNDS       = 5,
    parameter int unsigned MAX_ROUNDS   = 15,
    parameter int unsigned SHOT_TIMEOUT = 180,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       mode_sel,
    input  logic       shot_done,
    input  logic       shot_goal,
    output logic [2:0] game_state,
    output logic       game_mode,
    output logic       shot_active,
    output logic [3:0] score_player,
    output logic [3:0] score_cpu,
    output logic [3:0] round,
    output logic [7:0] frame_cnt
);

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned MARG_W  = 6;

    localparam logic [SCORE_W-1:0] ROUNDS_L     = SCORE_W'(ROUNDS);
    localparam logic [SCORE_W-1:0] MAX_ROUNDS_L = SCORE_W'(MAX_ROUNDS);
    localparam logic [CNT_W-1:0]   TIMEOUT_L    = CNT_W'(SHOT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   PAUSE_L      = CNT_W'(PAUSE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_MAX    = {SCORE_W{1'b1}};

    localparam logic [2:0] GS_START   = 3'd0;
    localparam logic [2:0] GS_KEEPER  = 3'd1;
    localparam logic [2:0] GS_SHOOTER = 3'd2;
    localparam logic [2:0] GS_WINNER  = 3'd3;
    localparam logic [2:0] GS_LOOSER  = 3'd4;

    typedef enum logic [2:0] {
        S_START,
        S_SHOOT_AIM,
        S_SHOOT_PAUSE,
        S_KEEP_AIM,
        S_KEEP_PAUSE,
        S_WIN,
        S_LOSE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               mode_next;
    logic [SCORE_W-1:0] sp_next;
    logic [SCORE_W-1:0] sc_next;
    logic [SCORE_W-1:0] round_next;
    logic [CNT_W-1:0]   cnt_next;
    logic [2:0]         gs_next;
    logic               active_next;

    logic               regulation;
    logic [MARG_W-1:0]  rem;
    logic [MARG_W-1:0]  sp_w;
    logic [MARG_W-1:0]  sc_w;
    logic               shoot_win;
    logic               shoot_lose;
    logic               keep_win;
    logic               keep_lose;
    logic               timeout_hit;
    logic               pause_done;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
    endfunction

    // Early-decision margins: rem is the shots each side has left after the
    // current pair; after the player shot the CPU still has one more.
    always_comb begin
        regulation = (round <= ROUNDS_L);
        rem        = regulation ? MARG_W'(ROUNDS_L - round) : '0;
        sp_w       = MARG_W'(score_player);
        sc_w       = MARG_W'(score_cpu);
        shoot_win  = sp_w > (sc_w + rem + MARG_W'(1));
        shoot_lose = sc_w > (sp_w + rem);
        keep_win   = sp_w > (sc_w + rem);
        keep_lose  = sc_w > (sp_w + rem);
    end

    assign timeout_hit = frame_tick && !game_mode && (frame_cnt == TIMEOUT_L);
    assign pause_done  = frame_tick && (frame_cnt == PAUSE_L);

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_next = state;
        mode_next  = game_mode;
        sp_next    = score_player;
        sc_next    = score_cpu;
        round_next = round;
        cnt_next   = (frame_tick && frame_cnt != CNT_MAX) ? frame_cnt + CNT_W'(1) : frame_cnt;

        case (state)
            S_START: begin
                if (start_btn) begin
                    state_next = S_SHOOT_AIM;
                    mode_next  = mode_sel;
                    sp_next    = '0;
                    sc_next    = '0;
                    round_next = SCORE_W'(1);
                    cnt_next   = '0;
                end
            end
            S_SHOOT_AIM: begin
                if (shot_done) begin
                    state_next = S_SHOOT_PAUSE;
                    cnt_next   = '0;
                    if (shot_goal) sp_next = sat_inc(score_player);
                end else if (timeout_hit) begin
                    state_next = S_SHOOT_PAUSE;
                    cnt_next   = '0;
                end
            end
            S_SHOOT_PAUSE: begin
                if (pause_done) begin
                    cnt_next = '0;
                    if (regulation && shoot_win)       state_next = S_WIN;
                    else if (regulation && shoot_lose) state_next = S_LOSE;
                    else                               state_next = S_KEEP_AIM;
                end
            end
            S_KEEP_AIM: begin
                if (shot_done) begin
                    state_next = S_KEEP_PAUSE;
                    cnt_next   = '0;
                    if (shot_goal) sc_next = sat_inc(score_cpu);
                end else if (timeout_hit) begin
                    state_next = S_KEEP_PAUSE;
                    cnt_next   = '0;
                end
            end
            S_KEEP_PAUSE: begin
                if (pause_done) begin
                    cnt_next = '0;
                    if (round < ROUNDS_L) begin
                        if (keep_win)       state_next = S_WIN;
                        else if (keep_lose) state_next = S_LOSE;
                        else begin
                            state_next = S_SHOOT_AIM;
                            round_next = round + SCORE_W'(1);
                        end
                    end else if (score_player > score_cpu) begin
                        state_next = S_WIN;
                    end else if (score_cpu > score_player) begin
                        state_next = S_LOSE;
                    end else if (round < MAX_ROUNDS_L) begin
                        // Sudden death: another pair while tied.
                        state_next = S_SHOOT_AIM;
                        round_next = round + SCORE_W'(1);
                    end else begin
                        state_next = S_LOSE;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (start_btn) begin
                    state_next = S_START;
                    sp_next    = '0;
                    sc_next    = '0;
                    round_next = '0;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_START;
                sp_next    = '0;
                sc_next    = '0;
                round_next = '0;
                cnt_next   = '0;
            end
        endcase

        gs_next     = GS_START;
        active_next = 1'b0;
        case (state_next)
            S_SHOOT_AIM:   begin gs_next = GS_SHOOTER; active_next = 1'b1; end
            S_SHOOT_PAUSE: gs_next = GS_SHOOTER;
            S_KEEP_AIM:    begin gs_next = GS_KEEPER;  active_next = 1'b1; end
            S_KEEP_PAUSE:  gs_next = GS_KEEPER;
            S_WIN:         gs_next = GS_WINNER;
            S_LOSE:        gs_next = GS_LOOSER;
            default:       gs_next = GS_START;
        endcase
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_START;
            game_state   <= GS_START;
            game_mode    <= 1'b0;
            shot_active  <= 1'b0;
            score_player <= '0;
            score_cpu    <= '0;
            round        <= '0;
            frame_cnt    <= '0;
        end else begin
            state        <= state_next;
            game_state   <= gs_next;
            game_mode    <= mode_next;
            shot_active  <= active_next;
            score_player <= sp_next;
            score_cpu    <= sc_next;
            round        <= round_next;
            frame_cnt    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_game_flow_ctl.sv
// Directed self-checking bench for game_flow_ctl with default parameters.
module tb_game_flow_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       start_btn;
    logic       mode_sel;
    logic       shot_done;
    logic       shot_goal;
    logic [2:0] game_state;
    logic       game_mode;
    logic       shot_active;
    logic [3:0] score_player;
    logic [3:0] score_cpu;
    logic [3:0] round;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    game_flow_ctl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .start_btn    (start_btn),
        .mode_sel     (mode_sel),
        .shot_done    (shot_done),
        .shot_goal    (shot_goal),
        .game_state   (game_state),
        .game_mode    (game_mode),
        .shot_active  (shot_active),
        .score_player (score_player),
        .score_cpu    (score_cpu),
        .round        (round),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic press_start(input logic m);
        mode_sel  = m;
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        mode_sel  = 1'b0;
    endtask

    task automatic shoot(input logic goal);
        shot_done = 1'b1;
        shot_goal = goal;
        step();
        shot_done = 1'b0;
        shot_goal = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    // One full pair: player shot, pause, CPU shot, pause.
    task automatic pair(input logic pgoal, input logic cgoal);
        shoot(pgoal);
        ticks(60);
        shoot(cgoal);
        ticks(60);
    endtask

    task automatic check_all(input string tag, input logic [2:0] gs, input logic act,
                             input logic [3:0] sp, input logic [3:0] sc, input logic [3:0] rd);
        check_eq({tag, ".state"},  16'(game_state),   16'(gs));
        check_eq({tag, ".active"}, 16'(shot_active),  16'(act));
        check_eq({tag, ".sp"},     16'(score_player), 16'(sp));
        check_eq({tag, ".sc"},     16'(score_cpu),    16'(sc));
        check_eq({tag, ".round"},  16'(round),        16'(rd));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start_btn = 1'b0;
        mode_sel = 1'b1; shot_done = 1'b1; shot_goal = 1'b1;
        step();
        step();
        shot_done = 1'b0; shot_goal = 1'b0; mode_sel = 1'b0;

        // Reset values hold even with inputs active.
        check_all("reset", 3'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        check_eq("reset.mode", 16'(game_mode), 16'd0);
        check_eq("reset.cnt",  16'(frame_cnt), 16'd0);
        rst_n = 1'b1;

        // MULTI start.
        press_start(1'b1);
        check_all("multi_start", 3'd2, 1'b1, 4'd0, 4'd0, 4'd1);
        check_eq("multi_start.mode", 16'(game_mode), 16'd1);
        // start_btn ignored mid-game.
        press_start(1'b0);
        check_eq("start_ignored.state", 16'(game_state), 16'd2);
        check_eq("start_ignored.mode",  16'(game_mode),  16'd1);

        // SOLO timeout path.
        do_reset();
        press_start(1'b0);
        check_eq("solo.mode", 16'(game_mode), 16'd0);
        ticks(179);
        check_eq("pre_timeout.active", 16'(shot_active), 16'd1);
        check_eq("pre_timeout.cnt",    16'(frame_cnt),   16'd179);
        ticks(1);
        check_all("timeout", 3'd2, 1'b0, 4'd0, 4'd0, 4'd1);
        check_eq("timeout.cnt", 16'(frame_cnt), 16'd0);
        ticks(59);
        check_eq("pause59.state", 16'(game_state), 16'd2);
        ticks(1);
        check_all("to_keeper", 3'd1, 1'b1, 4'd0, 4'd0, 4'd1);

        // Goal wins against a coincident timeout tick.
        do_reset();
        press_start(1'b0);
        ticks(179);
        frame_tick = 1'b1; shot_done = 1'b1; shot_goal = 1'b1;
        step();
        frame_tick = 1'b0; shot_done = 1'b0; shot_goal = 1'b0;
        check_all("goal_vs_timeout", 3'd2, 1'b0, 4'd1, 4'd0, 4'd1);
        shoot(1'b1);
        check_eq("pause_shot_ignored.sp", 16'(score_player), 16'd1);

        // Early win: 3:0 after pair 3.
        do_reset();
        press_start(1'b0);
        pair(1'b1, 1'b0);
        check_all("ew_pair1", 3'd2, 1'b1, 4'd1, 4'd0, 4'd2);
        pair(1'b1, 1'b0);
        pair(1'b1, 1'b0);
        check_all("early_win", 3'd3, 1'b0, 4'd3, 4'd0, 4'd3);
        press_start(1'b0);
        check_all("restart", 3'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        check_eq("restart.cnt", 16'(frame_cnt), 16'd0);

        // Early loss: 0:3 after pair 3.
        press_start(1'b0);
        pair(1'b0, 1'b1);
        pair(1'b0, 1'b1);
        pair(1'b0, 1'b1);
        check_all("early_loss", 3'd4, 1'b0, 4'd0, 4'd3, 4'd3);

        // 5:5 regulation then sudden-death win 6:5.
        do_reset();
        press_start(1'b1);
        for (int i = 0; i < 5; i++) pair(1'b1, 1'b1);
        check_all("sudden_death", 3'd2, 1'b1, 4'd5, 4'd5, 4'd6);
        pair(1'b1, 1'b0);
        check_all("sd_win", 3'd3, 1'b0, 4'd6, 4'd5, 4'd6);

        // Tied through MAX_ROUNDS ends in LOOSER.
        do_reset();
        press_start(1'b1);
        for (int i = 0; i < 15; i++) pair(1'b1, 1'b1);
        check_all("max_tie", 3'd4, 1'b0, 4'd15, 4'd15, 4'd15);

        // Mid-game reset from KEEPER/PAUSE at 2:1.
        do_reset();
        press_start(1'b0);
        pair(1'b1, 1'b1);
        shoot(1'b1);
        ticks(60);
        shoot(1'b0);
        check_all("kp_21", 3'd1, 1'b0, 4'd2, 4'd1, 4'd2);
        shoot(1'b1);
        check_eq("kp_shot_ignored.sc", 16'(score_cpu), 16'd1);
        ticks(3);
        rst_n = 1'b0;
        step();
        check_all("midgame_reset", 3'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        check_eq("midgame_reset.cnt",  16'(frame_cnt), 16'd0);
        check_eq("midgame_reset.mode", 16'(game_mode), 16'd0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
